tcp_option_encoder: RTL and testbench

//  Transmit-side TCP options serializer; counterpart of the options decoder. Latches

---
 rtl/tcp_option_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_tcp_option_encoder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_option_encoder.sv
// Transmit-side TCP options serializer: latches option fields on start, packs them
// into an EOL-padded big-endian byte buffer and streams 32-bit words via valid/ready.
module tcp_option_encoder #(
    parameter int MAX_OPT_BYTES = 40,
    parameter int SACK_MAX      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  opt_en,
    input  logic [15:0] mss,
    input  logic [7:0]  scale_wnd,
    input  logic [2:0]  sack_nbr,
    input  logic [63:0] sack_n0,
    input  logic [63:0] sack_n1,
    input  logic [63:0] sack_n2,
    input  logic [63:0] sack_n3,
    input  logic [63:0] time_stp,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        option_err,
    output logic [3:0]  opt_words,
    output logic [3:0]  data_off
);

    localparam int         MAX_WORDS = MAX_OPT_BYTES / 4;
    localparam int         BUF_BYTES = 64;
    localparam logic [6:0] MAX_LEN   = 7'(MAX_OPT_BYTES);
    localparam logic [2:0] SACK_LIM  = 3'(SACK_MAX);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        done_nxt;
    logic        err_nxt;
    logic [3:0]  idx;
    logic        last_word;
    logic        fire;

    logic        mss_en_r;
    logic        ws_en_r;
    logic        sp_en_r;
    logic        sack_en_r;
    logic        ts_en_r;
    logic [15:0] mss_r;
    logic [7:0]  ws_r;
    logic [2:0]  nbr_r;
    logic [63:0] sack_r [0:3];
    logic [63:0] ts_r;

    logic [7:0]  bytes [0:BUF_BYTES-1];
    logic [5:0]  pos;
    logic [6:0]  len;
    logic        build_err;
    logic [31:0] words [0:MAX_WORDS-1];

    logic unused_en;
    assign unused_en = ^{opt_en[7:6], opt_en[1:0]};

    function automatic logic [3:0] ceil_words(input logic [6:0] n);
        return 4'((n + 7'd3) >> 2);
    endfunction

    // Capture: option fields are sampled only when a start is accepted
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            mss_en_r  <= opt_en[2];
            ws_en_r   <= opt_en[3];
            sp_en_r   <= opt_en[4];
            sack_en_r <= opt_en[5];
            ts_en_r   <= opt_en[8];
            mss_r     <= mss;
            ws_r      <= scale_wnd;
            nbr_r     <= sack_nbr;
            sack_r[0] <= sack_n0;
            sack_r[1] <= sack_n1;
            sack_r[2] <= sack_n2;
            sack_r[3] <= sack_n3;
            ts_r      <= time_stp;
        end
    end

    // Assembly: options laid out back to back in fixed order, tail left as EOL (00)
    always_comb begin
        for (int i = 0; i < BUF_BYTES; i++) bytes[i] = 8'h00;
        pos = 6'd0;
        if (mss_en_r) begin
            bytes[pos]        = 8'h02;
            bytes[pos + 6'd1] = 8'h04;
            bytes[pos + 6'd2] = mss_r[15:8];
            bytes[pos + 6'd3] = mss_r[7:0];
            pos = pos + 6'd4;
        end
        if (ws_en_r) begin
            bytes[pos]        = 8'h03;
            bytes[pos + 6'd1] = 8'h03;
            bytes[pos + 6'd2] = ws_r;
            pos = pos + 6'd3;
        end
        if (sp_en_r) begin
            bytes[pos]        = 8'h04;
            bytes[pos + 6'd1] = 8'h02;
            pos = pos + 6'd2;
        end
        if (ts_en_r) begin
            bytes[pos]        = 8'h08;
            bytes[pos + 6'd1] = 8'h0A;
            for (int j = 0; j < 8; j++) bytes[pos + 6'd2 + 6'(j)] = ts_r[63 - 8*j -: 8];
            pos = pos + 6'd10;
        end
        if (sack_en_r) begin
            bytes[pos]        = 8'h05;
            bytes[pos + 6'd1] = 8'd2 + {2'b00, nbr_r, 3'b000};
            pos = pos + 6'd2;
            for (int k = 0; k < SACK_MAX; k++) begin
                if (3'(k) < nbr_r) begin
                    for (int j = 0; j < 8; j++) bytes[pos + 6'(j)] = sack_r[k][63 - 8*j -: 8];
                    pos = pos + 6'd8;
                end
            end
        end
    end

    // Length is computed from the full requested SACK count so oversize requests are caught
    always_comb begin
        len = 7'd0;
        if (mss_en_r)  len = len + 7'd4;
        if (ws_en_r)   len = len + 7'd3;
        if (sp_en_r)   len = len + 7'd2;
        if (ts_en_r)   len = len + 7'd10;
        if (sack_en_r) len = len + 7'd2 + {1'b0, nbr_r, 3'b000};
        build_err = (len > MAX_LEN) || (sack_en_r && (nbr_r == 3'd0 || nbr_r > SACK_LIM));
    end

    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            for (int w = 0; w < MAX_WORDS; w++)
                words[w] <= {bytes[4*w], bytes[4*w + 1], bytes[4*w + 2], bytes[4*w + 3]};
        end
    end

    assign fire      = (state == SEND) && out_ready;
    assign last_word = (idx == opt_words - 4'd1);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                if (build_err) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else if (len == 7'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_ready && last_word) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, word index, status pulses and the published word count
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 4'd0;
            done       <= 1'b0;
            option_err <= 1'b0;
            opt_words  <= 4'd0;
        end else begin
            state      <= state_nxt;
            done       <= done_nxt;
            option_err <= err_nxt;
            if (state == LOAD) idx <= 4'd0;
            else if (fire)     idx <= idx + 4'd1;
            if (state == LOAD && !build_err) opt_words <= ceil_words(len);
        end
    end

    assign out_valid = (state == SEND);
    assign out_last  = out_valid && last_word;
    assign out_data  = out_valid ? words[idx] : 32'h0;
    assign busy      = (state != IDLE);
    assign data_off  = 4'd5 + opt_words;

endmodule

// File: tb/tb_tcp_option_encoder.sv
// Randomized and directed bench for tcp_option_encoder with a byte-list reference model.
module tb_tcp_option_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  opt_en = '0;
    logic [15:0] mss = '0;
    logic [7:0]  scale_wnd = '0;
    logic [2:0]  sack_nbr = '0;
    logic [63:0] sack_n0 = '0, sack_n1 = '0, sack_n2 = '0, sack_n3 = '0;
    logic [63:0] time_stp = '0;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_valid, out_last, busy, done, option_err;
    logic [3:0]  opt_words, data_off;

    tcp_option_encoder dut (
        .clk(clk), .reset(reset), .start(start), .opt_en(opt_en), .mss(mss),
        .scale_wnd(scale_wnd), .sack_nbr(sack_nbr), .sack_n0(sack_n0), .sack_n1(sack_n1),
        .sack_n2(sack_n2), .sack_n3(sack_n3), .time_stp(time_stp), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
        .done(done), .option_err(option_err), .opt_words(opt_words), .data_off(data_off)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] got_q[$];
    bit          got_last_q[$];
    int          done_cnt, err_cnt, first_valid_cyc, hold_viol;
    bit          timeout, busy_at_done, valid_at_done, done_after;
    logic [31:0] exp_q[$];
    bit          exp_err;
    int          model_ow = 0;
    bit          bad;

    // Reference: list the option bytes in order, pad with zeros, pack four per word
    function automatic void run_model();
        logic [7:0]  b[$];
        logic [63:0] sk[4];
        int n;
        sk = '{sack_n0, sack_n1, sack_n2, sack_n3};
        n = int'(sack_nbr);
        exp_q.delete();
        if (opt_en[2]) begin
            b.push_back(8'h02); b.push_back(8'h04); b.push_back(mss[15:8]); b.push_back(mss[7:0]);
        end
        if (opt_en[3]) begin b.push_back(8'h03); b.push_back(8'h03); b.push_back(scale_wnd); end
        if (opt_en[4]) begin b.push_back(8'h04); b.push_back(8'h02); end
        if (opt_en[8]) begin
            b.push_back(8'h08); b.push_back(8'h0A);
            for (int k = 7; k >= 0; k--) b.push_back(time_stp[8*k +: 8]);
        end
        if (opt_en[5]) begin
            b.push_back(8'h05); b.push_back(8'(2 + 8*n));
            for (int blk = 0; blk < n && blk < 4; blk++)
                for (int k = 7; k >= 0; k--) b.push_back(sk[blk][8*k +: 8]);
        end
        exp_err = (opt_en[5] && (n == 0 || n > 4)) || (b.size() > 40);
        while (b.size() % 4 != 0) b.push_back(8'h00);
        for (int w = 0; w < b.size() / 4; w++)
            exp_q.push_back({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
        if (exp_err) exp_q.delete();
    endfunction

    // Drives one build and records the stream; mode 0 ready=1, 1 random, 2 stall 3 cycles
    task automatic run_build(input int mode);
        bit r, held_valid;
        logic [31:0] held_data;
        int stall;
        got_q.delete(); got_last_q.delete();
        done_cnt = 0; err_cnt = 0; first_valid_cyc = -1; hold_viol = 0; timeout = 1;
        held_valid = 0; held_data = '0; stall = 3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = i;
            if (out_valid && held_valid && out_data !== held_data) hold_viol++;
            if (mode == 1) r = bit'($urandom_range(0, 1));
            else if (mode == 2 && got_q.size() >= 1 && stall > 0) begin
                r = 1'b0; stall--; start = (stall > 0); mss = ~mss;
            end else r = 1'b1;
            out_ready = r;
            if (out_valid && r) begin
                got_q.push_back(out_data); got_last_q.push_back(out_last); held_valid = 0;
            end else if (out_valid) begin
                held_valid = 1; held_data = out_data;
            end
            if (done) begin
                done_cnt++; if (option_err) err_cnt++;
                busy_at_done = busy; valid_at_done = out_valid; timeout = 0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0; out_ready = 1'b0;
        @(negedge clk); done_after = done;
        if (timeout) begin
            n_tests++; n_fail++;
            $display("FAIL build_timeout: no done within budget (got %0d words)", got_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({out_valid, out_last, busy, done, option_err} !== 5'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid/last/busy/done/err=%b data=%h want 0", {out_valid, out_last, busy, done, option_err}, out_data);
        end
        n_tests++;
        if (opt_words !== 4'd0 || data_off !== 4'd5) begin
            n_fail++; $display("FAIL reset_counts: opt_words=%0d data_off=%0d want 0/5", opt_words, data_off);
        end
        reset = 1'b0; model_ow = 0;
        @(negedge clk);
    endtask

    task automatic test_mss();
        opt_en = 9'h004; mss = 16'd1460;
        run_build(0);
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 32'h020405B4 || got_last_q[0] !== 1'b1) begin
            n_fail++; $display("FAIL mss_word: n=%0d w0=%h want 1 word 020405B4 last", got_q.size(), got_q[0]);
        end
        n_tests++;
        if (first_valid_cyc != 2) begin
            n_fail++; $display("FAIL mss_latency: first valid at %0d want 2", first_valid_cyc);
        end
        n_tests++;
        if (done_cnt != 1 || err_cnt != 0 || busy_at_done || valid_at_done || done_after) begin
            n_fail++; $display("FAIL mss_done: done=%0d err=%0d busy=%b valid=%b after=%b", done_cnt, err_cnt, busy_at_done, valid_at_done, done_after);
        end
        n_tests++;
        if (opt_words !== 4'd1 || data_off !== 4'd6) begin
            n_fail++; $display("FAIL mss_counts: opt_words=%0d data_off=%0d want 1/6", opt_words, data_off);
        end
        model_ow = 1;
    endtask

    task automatic test_mss_ws();
        opt_en = 9'h00C; mss = 16'd1460; scale_wnd = 8'd7;
        run_build(0);
        n_tests++;
        if (got_q.size() != 2 || got_q[0] !== 32'h020405B4 || got_q[1] !== 32'h03030700 ||
            got_last_q[0] !== 1'b0 || got_last_q[1] !== 1'b1) begin
            n_fail++; $display("FAIL mss_ws_words: n=%0d w0=%h w1=%h want 020405B4 03030700", got_q.size(), got_q[0], got_q[1]);
        end
        n_tests++;
        if (done_cnt != 1 || err_cnt != 0 || opt_words !== 4'd2) begin
            n_fail++; $display("FAIL mss_ws_status: done=%0d err=%0d opt_words=%0d want 1/0/2", done_cnt, err_cnt, opt_words);
        end
        model_ow = 2;
    endtask

    task automatic test_ts();
        opt_en = 9'h100; time_stp = 64'h11223344_55667788;
        run_build(0);
        n_tests++;
        if (got_q.size() != 3 || got_q[0] !== 32'h080A1122 || got_q[1] !== 32'h33445566 ||
            got_q[2] !== 32'h77880000 || got_last_q[2] !== 1'b1) begin
            n_fail++; $display("FAIL ts_words: n=%0d %h %h %h want 080A1122 33445566 77880000", got_q.size(), got_q[0], got_q[1], got_q[2]);
        end
        n_tests++;
        if (opt_words !== 4'd3 || data_off !== 4'd8) begin
            n_fail++; $display("FAIL ts_counts: opt_words=%0d data_off=%0d want 3/8", opt_words, data_off);
        end
        model_ow = 3;
    endtask

    task automatic test_sack_limits();
        opt_en = 9'h120; time_stp = {$urandom, $urandom};
        sack_n0 = {$urandom, $urandom}; sack_n1 = {$urandom, $urandom};
        sack_n2 = {$urandom, $urandom}; sack_n3 = {$urandom, $urandom};
        sack_nbr = 3'd3;
        run_model();
        run_build(0);
        bad = (got_q.size() != 9) || (exp_q.size() != 9) || exp_err;
        for (int k = 0; k < got_q.size() && !bad; k++)
            if (got_q[k] !== exp_q[k] || got_last_q[k] !== (k == 8)) bad = 1;
        n_tests++;
        if (bad || opt_words !== 4'd9 || err_cnt != 0) begin
            n_fail++; $display("FAIL sack3_ts: n=%0d opt_words=%0d err=%0d want 9/9/0", got_q.size(), opt_words, err_cnt);
        end
        model_ow = 9;
        sack_nbr = 3'd4;
        run_build(0);
        n_tests++;
        if (got_q.size() != 0 || first_valid_cyc != -1 || done_cnt != 1 || err_cnt != 1) begin
            n_fail++; $display("FAIL sack4_ts_err: words=%0d valid_at=%0d done=%0d err=%0d want 0/-1/1/1", got_q.size(), first_valid_cyc, done_cnt, err_cnt);
        end
        n_tests++;
        if (opt_words !== 4'd9 || data_off !== 4'd14 || done_after) begin
            n_fail++; $display("FAIL sack4_hold: opt_words=%0d data_off=%0d after=%b want 9/14/0", opt_words, data_off, done_after);
        end
        opt_en = 9'h020; sack_nbr = 3'd0;
        run_build(0);
        n_tests++;
        if (got_q.size() != 0 || err_cnt != 1 || opt_words !== 4'd9) begin
            n_fail++; $display("FAIL sack0_err: words=%0d err=%0d opt_words=%0d want 0/1/9", got_q.size(), err_cnt, opt_words);
        end
    endtask

    task automatic test_zero_len();
        opt_en = 9'h0C3;
        run_build(0);
        n_tests++;
        if (got_q.size() != 0 || done_cnt != 1 || err_cnt != 0 || opt_words !== 4'd0 || data_off !== 4'd5) begin
            n_fail++; $display("FAIL zero_len: words=%0d done=%0d err=%0d ow=%0d doff=%0d want 0/1/0/0/5", got_q.size(), done_cnt, err_cnt, opt_words, data_off);
        end
        model_ow = 0;
    endtask

    task automatic test_back_to_back();
        opt_en = 9'h104; mss = 16'($urandom); time_stp = {$urandom, $urandom};
        run_model();
        run_build(2);
        bad = (got_q.size() != exp_q.size()) || (exp_q.size() != 4);
        for (int k = 0; k < got_q.size() && !bad; k++)
            if (got_q[k] !== exp_q[k] || got_last_q[k] !== (k == 3)) bad = 1;
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL stall_stream: n=%0d w1=%h want 4 words w1=%h", got_q.size(), got_q[1], exp_q[1]);
        end
        n_tests++;
        if (hold_viol != 0 || done_cnt != 1 || opt_words !== 4'd4) begin
            n_fail++; $display("FAIL stall_hold: hold_viol=%0d done=%0d ow=%0d want 0/1/4", hold_viol, done_cnt, opt_words);
        end
        model_ow = 4;
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        opt_en = 9'h100; time_stp = 64'h11223344_55667788;
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h33445566) begin
            n_fail++; $display("FAIL rst_mid_word2: valid=%b data=%h want 1/33445566", out_valid, out_data);
        end
        reset = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_abort: valid=%b busy=%b done=%b want 0/0/0", out_valid, busy, done);
        end
        model_ow = 0;
        saw_done = 0;
        repeat (4) begin @(negedge clk); if (done || out_valid) saw_done = 1; end
        n_tests++;
        if (saw_done) begin
            n_fail++; $display("FAIL rst_mid_quiet: done or valid seen after reset, want none");
        end
        opt_en = 9'h004; mss = 16'd1460;
        run_build(0);
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 32'h020405B4 || done_cnt != 1) begin
            n_fail++; $display("FAIL rst_mid_restart: n=%0d w0=%h done=%0d want 1/020405B4/1", got_q.size(), got_q[0], done_cnt);
        end
        model_ow = 1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            opt_en = 9'($urandom); mss = 16'($urandom); scale_wnd = 8'($urandom);
            sack_nbr = 3'($urandom_range(0, 5)); time_stp = {$urandom, $urandom};
            sack_n0 = {$urandom, $urandom}; sack_n1 = {$urandom, $urandom};
            sack_n2 = {$urandom, $urandom}; sack_n3 = {$urandom, $urandom};
            run_model();
            run_build(1);
            if (!exp_err) model_ow = exp_q.size();
            bad = (got_q.size() != exp_q.size());
            for (int k = 0; k < got_q.size() && !bad; k++)
                if (got_q[k] !== exp_q[k] || got_last_q[k] !== (k == exp_q.size() - 1)) bad = 1;
            n_tests++;
            if (bad || hold_viol != 0) begin
                n_fail++; $display("FAIL rand_stream[%0d]: en=%h nbr=%0d n=%0d want %0d hold_viol=%0d", it, opt_en, sack_nbr, got_q.size(), exp_q.size(), hold_viol);
            end
            n_tests++;
            if (done_cnt != 1 || err_cnt != int'(exp_err) || done_after || opt_words !== 4'(model_ow) ||
                data_off !== 4'(5 + model_ow)) begin
                n_fail++; $display("FAIL rand_status[%0d]: done=%0d err=%0d ow=%0d doff=%0d want 1/%0d/%0d/%0d", it, done_cnt, err_cnt, opt_words, data_off, exp_err, model_ow, 5 + model_ow);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mss();
        test_mss_ws();
        test_ts();
        test_sack_limits();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
